// File: rtl/mux16_rr_arbiter_if.sv
// rtl/mux16_rr_arbiter_if.sv - request/data/grant bundle between 16 requesters and the mux arbiter
interface mux16_rr_arbiter_if;
  logic [15:0] req;
  logic [15:0] data_in;
  logic [15:0] grant;
  logic [3:0]  sel;
  logic        valid;
  logic        y;
  logic        timeout;

  modport master (
    output req,
    output data_in,
    input  grant,
    input  sel,
    input  valid,
    input  y,
    input  timeout
  );

  modport slave (
    input  req,
    input  data_in,
    output grant,
    output sel,
    output valid,
    output y,
    output timeout
  );
endinterface

// File: rtl/mux16_rr_arbiter.sv
// rtl/mux16_rr_arbiter.sv - round-robin arbiter owning the select lines of a 16:1 single-bit mux
module mux16_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  mux16_rr_arbiter_if.slave bus
);

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  owner_q, owner_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [15:0] grant_q, grant_d;
  logic        valid_q, valid_d;
  logic        y_q, y_d;
  logic        timeout_q, timeout_d;

  logic        pick_found;
  logic [3:0]  pick_idx;
  logic [3:0]  cand;

  // Rotating priority scan: first requester at or after ptr, wrapping 15 -> 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    for (int k = 0; k < 16; k++) begin
      cand = ptr_q + 4'(k);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    valid_d    = valid_q;
    timeout_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        // The gap cycle exits exactly like idle, so arbitration happens on its exit edge.
        state_d    = ST_IDLE;
        grant_d    = 16'h0000;
        valid_d    = 1'b0;
        hold_cnt_d = 8'd0;
        if (pick_found) begin
          state_d    = ST_BUSY;
          owner_d    = pick_idx;
          grant_d    = 16'(1) << pick_idx;
          valid_d    = 1'b1;
          hold_cnt_d = 8'd1;
        end
      end

      ST_BUSY: begin
        if (!bus.req[owner_q] || (hold_cnt_q == MAX_HOLD_C)) begin
          state_d    = ST_GAP;
          grant_d    = 16'h0000;
          valid_d    = 1'b0;
          hold_cnt_d = 8'd0;
          ptr_d      = owner_q + 4'd1;
          timeout_d  = bus.req[owner_q];
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        grant_d    = 16'h0000;
        valid_d    = 1'b0;
        hold_cnt_d = 8'd0;
      end
    endcase
  end

  // Data bit is registered alongside the grant so y lines up with grant/sel.
  always_comb begin
    y_d = 1'b0;
    if (valid_d) begin
      y_d = bus.data_in[owner_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 4'd0;
      owner_q    <= 4'd0;
      hold_cnt_q <= 8'd0;
      grant_q    <= 16'h0000;
      valid_q    <= 1'b0;
      y_q        <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      y_q        <= y_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.sel     = owner_q;
  assign bus.valid   = valid_q;
  assign bus.y       = y_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb/tb_mux16_rr_arbiter.sv - randomized model-checked bench for two arbiter instances (hold 8 and 4)
module tb_mux16_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux16_rr_arbiter_if bus8 ();
  mux16_rr_arbiter_if bus4 ();

  mux16_rr_arbiter #(.MAX_HOLD(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  mux16_rr_arbiter #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  int total = 0;
  int bad   = 0;

  // Reference state per instance: owner index or -1, last select, priority start, cycles held.
  int m_owner [2];
  int m_sel   [2];
  int m_ptr   [2];
  int m_held  [2];
  int m_tmo   [2];
  int m_y     [2];
  int maxh    [2] = '{8, 4};

  int prev_valid;
  int got_q [$];
  int tmo_cnt [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_sel[d]   = 0;
      m_ptr[d]   = 0;
      m_held[d]  = 0;
      m_tmo[d]   = 0;
      m_y[d]     = 0;
    end
  endtask

  task automatic model_step(input logic [15:0] r, input logic [15:0] dat);
    for (int d = 0; d < 2; d++) begin
      m_tmo[d] = 0;
      if (m_owner[d] >= 0) begin
        if (!r[m_owner[d]]) begin
          m_ptr[d]   = (m_owner[d] + 1) % 16;
          m_owner[d] = -1;
        end else if (m_held[d] == maxh[d]) begin
          m_ptr[d]   = (m_owner[d] + 1) % 16;
          m_owner[d] = -1;
          m_tmo[d]   = 1;
        end else begin
          m_held[d]++;
        end
      end else begin
        for (int k = 0; k < 16; k++) begin
          if (m_owner[d] < 0 && r[(m_ptr[d] + k) % 16]) begin
            m_owner[d] = (m_ptr[d] + k) % 16;
            m_sel[d]   = m_owner[d];
            m_held[d]  = 1;
          end
        end
      end
      m_y[d] = (m_owner[d] >= 0) ? int'(dat[m_owner[d]]) : 0;
    end
  endtask

  task automatic compare_all();
    logic [15:0] g;
    logic [3:0]  s;
    logic        v, yy, t;
    logic [31:0] eg;
    for (int d = 0; d < 2; d++) begin
      g  = (d == 0) ? bus8.grant   : bus4.grant;
      s  = (d == 0) ? bus8.sel     : bus4.sel;
      v  = (d == 0) ? bus8.valid   : bus4.valid;
      yy = (d == 0) ? bus8.y       : bus4.y;
      t  = (d == 0) ? bus8.timeout : bus4.timeout;
      eg = (m_owner[d] >= 0) ? (32'd1 << m_owner[d]) : 32'd0;
      check($sformatf("d%0d.grant", d),   32'(g),  eg);
      check($sformatf("d%0d.sel", d),     32'(s),  32'(m_sel[d]));
      check($sformatf("d%0d.valid", d),   32'(v),  32'(m_owner[d] >= 0));
      check($sformatf("d%0d.y", d),       32'(yy), 32'(m_y[d]));
      check($sformatf("d%0d.timeout", d), 32'(t),  32'(m_tmo[d]));
      if (t === 1'b1) tmo_cnt[d]++;
    end
    if (bus8.valid === 1'b1 && prev_valid == 0) got_q.push_back(int'(bus8.sel));
    prev_valid = (bus8.valid === 1'b1) ? 1 : 0;
  endtask

  task automatic tick(input logic [15:0] r, input logic [15:0] dat);
    bus8.req = r; bus8.data_in = dat;
    bus4.req = r; bus4.data_in = dat;
    model_step(r, dat);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    bus8.req = 16'h0; bus8.data_in = 16'h0;
    bus4.req = 16'h0; bus4.data_in = 16'h0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    prev_valid = 0;
  endtask

  initial begin
    logic [15:0] dat;
    logic [15:0] r;
    rst = 1'b1;
    bus8.req = 16'h0; bus8.data_in = 16'h0;
    bus4.req = 16'h0; bus4.data_in = 16'h0;
    model_reset();
    prev_valid = 0;
    tmo_cnt[0] = 0;
    tmo_cnt[1] = 0;
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Single request held three cycles, then dropped.
    repeat (3) tick(16'h0008, 16'(($urandom)));
    repeat (4) tick(16'h0000, 16'(($urandom)));

    // Asynchronous reset in the middle of a grant.
    repeat (2) tick(16'h0010, 16'hFFFF);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.grant", 32'(bus8.grant), 32'd0);
    check("async_rst.sel",   32'(bus8.sel),   32'd0);
    check("async_rst.valid", 32'(bus8.valid), 32'd0);
    check("async_rst.y",     32'(bus8.y),     32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    prev_valid = 0;

    // Everyone requesting: strict rotation with one timeout per owner.
    do_reset();
    got_q.delete();
    tmo_cnt[0] = 0;
    tmo_cnt[1] = 0;
    repeat (16 * 9 + 4) tick(16'hFFFF, 16'($urandom));
    for (int i = 0; i < 17; i++) begin
      check($sformatf("rr_order%0d", i), 32'((i < got_q.size()) ? got_q[i] : 99), 32'(i % 16));
    end
    check("rr_tmo8", 32'(tmo_cnt[0]), 32'd16);
    check("rr_tmo4", 32'(tmo_cnt[1]), 32'd29);

    // Pointer wrap after owner 14 releases.
    do_reset();
    repeat (2) tick(16'h4000, 16'($urandom));
    tick(16'h0000, 16'($urandom));
    got_q.delete();
    repeat (20) tick(16'h8001, 16'($urandom));
    check("wrap0", 32'((got_q.size() > 0) ? got_q[0] : 99), 32'd15);
    check("wrap1", 32'((got_q.size() > 1) ? got_q[1] : 99), 32'd0);
    check("wrap2", 32'((got_q.size() > 2) ? got_q[2] : 99), 32'd15);

    // Data path follows the owner's bit with one cycle of latency.
    do_reset();
    tick(16'h0020, 16'($urandom));
    for (int i = 0; i < 3; i++) begin
      dat = 16'($urandom);
      dat[5] = (i != 1);
      tick(16'h0020, dat);
      check($sformatf("dp_y8_%0d", i), 32'(bus8.y), 32'(i != 1));
      check($sformatf("dp_y4_%0d", i), 32'(bus4.y), 32'(i != 1));
    end
    tick(16'h0000, 16'hFFFF);
    check("dp_gap_y8", 32'(bus8.y), 32'd0);
    tick(16'h0000, 16'hFFFF);
    check("dp_idle_y8", 32'(bus8.y), 32'd0);

    // Lone requester keeps timing out and is re-granted after each gap.
    do_reset();
    tmo_cnt[0] = 0;
    tmo_cnt[1] = 0;
    repeat (20) tick(16'h0002, 16'($urandom));
    check("lone_tmo4", 32'(tmo_cnt[1]), 32'd4);
    check("lone_tmo8", 32'(tmo_cnt[0]), 32'd2);

    // Random traffic, dense and sparse.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       r = 16'($urandom);
        1:       r = 16'($urandom) & 16'($urandom) & 16'($urandom);
        2:       r = 16'(1) << $urandom_range(0, 15);
        default: r = bus8.req;
      endcase
      tick(r, 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
